// File: rtl/uart_rx_if.sv
// Host-side holding-register interface of uart_rx: valid/ready handshake plus status flags.
// UART_RX_PARITY_EN adds the o_parity_error flag.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] o_data;
   logic                 o_valid;
   logic                 i_ready;
   logic                 o_frame_error;
   logic                 o_overrun;
   logic                 o_busy;
`ifdef UART_RX_PARITY_EN
   logic                 o_parity_error;

   modport master (
      output o_data, o_valid, o_frame_error, o_overrun, o_busy, o_parity_error,
      input  i_ready
   );

   modport slave (
      input  o_data, o_valid, o_frame_error, o_overrun, o_busy, o_parity_error,
      output i_ready
   );
`else
   modport master (
      output o_data, o_valid, o_frame_error, o_overrun, o_busy,
      input  i_ready
   );

   modport slave (
      input  o_data, o_valid, o_frame_error, o_overrun, o_busy,
      output i_ready
   );
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8N1 by default, one-byte holding register with valid/ready.
// UART_RX_PARITY_EN inserts an even-parity bit between data and stop and adds o_parity_error.
module uart_rx #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned SAMPLE_POINT = OVERSAMPLE / 2 - 1
) (
   input  logic      i_clock,
   input  logic      i_reset,
   input  logic      i_rxce,
   input  logic      i_rx,
   uart_rx_if.master bus
);
   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_SAMPLE = TICK_W'(SAMPLE_POINT);
   localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 rx_meta, rx_sync;
   logic                 deliver_c;
   logic                 accept_c;
`ifdef UART_RX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   assign accept_c = bus.o_valid & bus.i_ready;

   // Two-flop synchroniser for the asynchronous line, idle high
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   // FSM state, counters, shift register and busy flag
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         bus.o_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         bus.o_busy <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // Next-state logic; everything advances only on an oversample tick
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      deliver_c = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (i_rxce) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_sync) begin
                  state_d = S_START;
                  tick_d  = '0;
               end
            end
            S_START: begin
               if (tick_q == TICK_SAMPLE) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_sync ? S_IDLE : S_DATA;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
            S_DATA: begin
               if (tick_q == TICK_LAST) begin
                  shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                  tick_d  = '0;
                  bit_d   = bit_q + BIT_W'(1);
                  if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick_q == TICK_LAST) begin
                  parity_d = rx_sync;
                  tick_d   = '0;
                  state_d  = S_STOP;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (tick_q == TICK_LAST) begin
                  deliver_c = 1'b1;
                  tick_d    = '0;
                  state_d   = rx_sync ? S_IDLE : S_BREAK;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
            S_BREAK: begin
               // Wait for the line to return high so a held-low line cannot restart a frame
               if (rx_sync) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Holding register: load on delivery when free or being read, else flag overrun
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         bus.o_data         <= '0;
         bus.o_valid        <= 1'b0;
         bus.o_frame_error  <= 1'b0;
         bus.o_overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.o_parity_error <= 1'b0;
`endif
      end else if (deliver_c && (!bus.o_valid || accept_c)) begin
         bus.o_data         <= shift_q;
         bus.o_valid        <= 1'b1;
         bus.o_frame_error  <= ~rx_sync;
         bus.o_overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.o_parity_error <= ^{shift_q, parity_q};
`endif
      end else if (deliver_c) begin
         bus.o_overrun      <= 1'b1;
      end else if (accept_c) begin
         bus.o_valid        <= 1'b0;
         bus.o_frame_error  <= 1'b0;
         bus.o_overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.o_parity_error <= 1'b0;
`endif
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit on the serial line,
// expected bytes/flags are queued at send time and checked when the host accepts.
module tb_uart_rx;
   localparam int unsigned DB = 8;
   localparam int unsigned OS = 16;

   logic i_clock = 1'b0;
   logic i_reset = 1'b1;
   logic i_rxce  = 1'b0;
   logic i_rx    = 1'b1;

   uart_rx_if #(.DATA_BITS(DB)) bus ();

   uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_rxce  (i_rxce),
      .i_rx    (i_rx),
      .bus     (bus)
   );

   always #5 i_clock = ~i_clock;

   // Oversample tick: one clock high every three clocks
   int unsigned ce_cnt = 0;
   always @(posedge i_clock) begin
      ce_cnt <= (ce_cnt == 2) ? 0 : ce_cnt + 1;
      i_rxce <= (ce_cnt == 2);
   end

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic       ovr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   model_full = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) @(posedge i_clock iff i_rxce);
      #1;
   endtask

   // Reference model: one-byte holding register; a frame arriving while full is dropped
   task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      if (!bus.i_ready && model_full) begin
         exp_q[exp_q.size()-1].ovr = 1'b1;
      end else begin
         e.data = d; e.fe = fe; e.pe = pe; e.ovr = 1'b0;
         exp_q.push_back(e);
         if (!bus.i_ready) model_full = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                             input int low_hold, input bit release_line);
      expect_frame(d, ~stop, (^d) ^ pbit);
      i_rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < DB; i++) begin
         i_rx = d[i];
         wait_ticks(OS);
      end
`ifdef UART_RX_PARITY_EN
      i_rx = pbit;
      wait_ticks(OS);
`endif
      i_rx = stop;
      wait_ticks(OS);
      if (!stop) wait_ticks(low_hold);
      if (release_line) begin
         i_rx = 1'b1;
         wait_ticks(4);
      end
   endtask

   // Monitor: every accepted byte is compared against the head of the queue
   always @(negedge i_clock) begin
      exp_t e;
      if (!i_reset && bus.o_valid && bus.i_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame actual data=%0h required none @%0t", bus.o_data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("data", 32'(bus.o_data), 32'(e.data));
            chk("frame_error", 32'(bus.o_frame_error), 32'(e.fe));
            chk("overrun", 32'(bus.o_overrun), 32'(e.ovr));
`ifdef UART_RX_PARITY_EN
            chk("parity_error", 32'(bus.o_parity_error), 32'(e.pe));
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       stop;
      logic       pbit;
      bus.i_ready = 1'b1;
      repeat (3) @(posedge i_clock);
      #1 i_reset = 1'b0;
      chk("rst_valid", 32'(bus.o_valid), 0);
      chk("rst_data", 32'(bus.o_data), 0);
      chk("rst_fe", 32'(bus.o_frame_error), 0);
      chk("rst_ovr", 32'(bus.o_overrun), 0);
      chk("rst_busy", 32'(bus.o_busy), 0);
      wait_ticks(4);

      // Clean frame
      send_frame(8'h55, 1'b1, 1'b0, 0, 1'b1);
      chk("idle_after_55", 32'(bus.o_busy), 0);

      // Start-bit glitch
      i_rx = 1'b0;
      wait_ticks(2);
      chk("glitch_busy", 32'(bus.o_busy), 1);
      wait_ticks(2);
      i_rx = 1'b1;
      wait_ticks(12);
      chk("glitch_idle", 32'(bus.o_busy), 0);
      chk("glitch_valid", 32'(bus.o_valid), 0);

      // Framing error with the line held low afterwards
      send_frame(8'hA3, 1'b0, 1'b0, 24, 1'b0);
      chk("break_busy", 32'(bus.o_busy), 1);
      i_rx = 1'b1;
      wait_ticks(4);
      chk("break_released", 32'(bus.o_busy), 0);

      // Overrun while the host is stalled
      bus.i_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 0, 1'b1);
      send_frame(8'h22, 1'b1, 1'b0, 0, 1'b1);
      chk("ovr_valid", 32'(bus.o_valid), 1);
      chk("ovr_data", 32'(bus.o_data), 32'h11);
      chk("ovr_flag", 32'(bus.o_overrun), 1);
      @(posedge i_clock);
      #1 bus.i_ready = 1'b1;
      @(posedge i_clock);
      #1 bus.i_ready = 1'b0;
      model_full = 1'b0;
      chk("ovr_cleared_valid", 32'(bus.o_valid), 0);
      chk("ovr_cleared_flag", 32'(bus.o_overrun), 0);
      bus.i_ready = 1'b1;

      // Reset in the middle of a frame
      i_rx = 1'b0;
      wait_ticks(OS);
      i_rx = 1'b1;
      wait_ticks(4 * OS + 6);
      @(posedge i_clock);
      #1 i_reset = 1'b1;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 1'b0;
      chk("midrst_busy", 32'(bus.o_busy), 0);
      chk("midrst_data", 32'(bus.o_data), 0);
      wait_ticks(20);
      chk("midrst_idle", 32'(bus.o_busy), 0);
      chk("midrst_valid", 32'(bus.o_valid), 0);
      send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b1);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1, 0, 1'b1);
`endif

      // Randomised frames with occasional framing and parity errors
      for (int n = 0; n < 12; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(3) != 0);
         pbit = (^d) ^ ($urandom_range(3) == 0);
         send_frame(d, stop, pbit, int'($urandom_range(8)), 1'b1);
         wait_ticks(int'($urandom_range(5)));
      end

      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge i_clock);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver with 16x oversampling. Consumes the oversample clock-enable tick from the baud generator (`rxce`) and the asynchronous serial line.
- Deserialises 8N1 frames, LSB first, into a one-byte holding register.
- The holding register is presented to the host side with a valid/ready handshake, plus frame-error and overrun flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, `i_rxce` ticks per bit period. Must be even and at least 4.
- SAMPLE_POINT, OVERSAMPLE/2-1, tick index within the start bit at which mid-bit is declared.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous active-high reset.
- i_rxce  in  1  oversample tick, one i_clock cycle wide, from the baud generator.
- i_rx  in  1  asynchronous serial input, idle high.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_data  out  DATA_BITS  received byte, LSB = first bit on the line.
- o_valid  out  1  o_data holds an unread byte.
- o_frame_error  out  1  stop bit of the held byte sampled low.
- o_overrun  out  1  at least one frame was dropped while o_valid was pending.
- o_busy  out  1  the FSM is not in IDLE.

Behaviour:
- Clock and reset: i_reset is synchronous and active-high; the clock is i_clock.
- Reset values: o_data=0, o_valid=0, o_frame_error=0, o_overrun=0, o_busy=0, FSM=IDLE, tick/bit counters=0, synchroniser flops=1.
- Synchroniser: i_rx passes through 2 flip-flops on every i_clock. Every FSM decision uses the synchronised value, and only in cycles where i_rxce=1.
- The FSM and tick counter (width $clog2(OVERSAMPLE)) advance only on i_rxce. Handshake logic runs every i_clock.
- IDLE: on i_rxce with rx=0, go to START with tick=0.
- START: tick increments each i_rxce.
  - At tick==SAMPLE_POINT with rx=0: go to DATA with tick=0 and bit=0.
  - At tick==SAMPLE_POINT with rx=1: glitch, return to IDLE with no output.
- DATA: at tick==OVERSAMPLE-1 (one bit period after the previous sample):
  - Shift rx into the shift register MSB side, so the LSB ends up first. Set tick=0 and bit++.
  - After DATA_BITS samples, go to STOP.
- STOP: at tick==OVERSAMPLE-1, sample the stop bit.
  - Stop bit 1: go to IDLE.
  - Stop bit 0: go to BREAK.
  - In both cases, deliver the frame (see below).
- BREAK: on i_rxce with rx=1, go to IDLE. Prevents a held-low line from retriggering START.
- Delivery (same cycle as the stop sample), with `accept = o_valid & i_ready` evaluated in that cycle:
  - If !o_valid or accept: load o_data, set o_valid=1, set o_frame_error=~stopbit.
  - Otherwise: discard the new frame, set o_overrun=1, keep o_data and o_frame_error.
- Accept without a new load in the same cycle: clear o_valid, o_frame_error and o_overrun.
- Accept together with a load: o_valid stays 1, o_overrun cleared, new data and flag loaded.
- Latency: o_valid rises on the i_clock edge after the i_rxce cycle that samples the stop bit.
- o_busy=1 in START, DATA, STOP and BREAK.
- Reset mid-frame: immediate return to IDLE. A partial byte is never delivered, and the holding register is cleared.
- i_rxce held low: the FSM freezes, while the handshake still operates.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and samples one even-parity bit at tick==OVERSAMPLE-1. Extra output o_parity_error (1 bit, reset 0) is loaded and cleared exactly like o_frame_error. It is set when XOR(data bits, parity bit)=1.
- Not defined: no PARITY state and no o_parity_error port. The frame is 8N1 only.

Test Plan:
- Common setup: i_rxce pulses every 3 clocks; i_ready=1 unless stated otherwise.
- Frame 0x55 with a good stop bit -> o_valid pulses once; o_data=0x55; o_frame_error=0; o_overrun=0.
- Start glitch: i_rx low for 4 rxce ticks, then high -> FSM returns to IDLE, o_valid stays 0, o_busy drops after SAMPLE_POINT ticks.
- Frame 0xA3 with stop bit 0, line held low for 40 ticks, then high -> o_data=0xA3 and o_frame_error=1. Exactly one frame is delivered, and no new START occurs until the line goes high.
- i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11 and o_overrun=1. Raising i_ready for 1 cycle clears o_valid and o_overrun.
- Assert i_reset during bit 4 of frame 0xFF, then send 0x3C -> no output from the aborted frame; o_data=0x3C is delivered cleanly.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> o_parity_error=1. Send 0x07 with parity bit 1 -> o_parity_error=0.
